obstacle_sprite_mover: RTL

- Parametrised successor to the single-obstacle plot/erase/move engine for the 160x120 VGA road scene.
- Draws a W x H rectangle at (pos_x, pos_y) and waits a programmable number of frames.
- Then erases the rectangle in background colour, advances horizontally by STEP pixels in either bounce or wrap mode, and redraws.
- Drives the VGA adapter pixel port directly and exports the obstacle position for collision logic.

---
 rtl/obstacle_sprite_mover_pkg.sv | 21 ++
 rtl/frame_step_timer.sv | 46 ++++
 rtl/obstacle_sprite_mover.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/obstacle_sprite_mover_pkg.sv
// Shared types and constants for the obstacle sprite engine on the 160x120 road scene.
package obstacle_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GO_WAIT = 3'd1,
        PLOT    = 3'd2,
        RST_TMR = 3'd3,
        WAIT    = 3'd4,
        ERASE   = 3'd5,
        UPDATE  = 3'd6
    } state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] RED   = 3'b100;

endpackage

// File: rtl/frame_step_timer.sv
// Frame tick generator plus a frame counter that pulses step on every FRAMES_PER_STEP-th tick.
module frame_step_timer #(
    parameter int FRAME_CYCLES    = 833333,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int CW = (FRAME_CYCLES    > 1) ? $clog2(FRAME_CYCLES)    : 1;
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [CW-1:0] cyc_q, cyc_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          tick;

    always_comb begin
        tick  = en && (cyc_q == CW'(FRAME_CYCLES - 1));
        step  = tick && (frm_q == FW'(FRAMES_PER_STEP - 1));
        cyc_d = cyc_q;
        frm_d = frm_q;
        if (clr) begin
            cyc_d = '0;
            frm_d = '0;
        end else if (en) begin
            cyc_d = tick ? '0 : cyc_q + CW'(1);
            if (tick) begin
                frm_d = step ? '0 : frm_q + FW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            frm_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            frm_q <= frm_d;
        end
    end

endmodule

// File: rtl/obstacle_sprite_mover.sv
// Plot / wait / erase / move engine for one W x H obstacle driving the VGA adapter pixel port.
module obstacle_sprite_mover
    import obstacle_pkg::*;
#(
    parameter int         W               = 8,
    parameter int         H               = 8,
    parameter int         X_MAX           = 159,
    parameter int         INIT_X          = 0,
    parameter int         INIT_Y          = 25,
    parameter int         INIT_DIR        = 1,
    parameter int         STEP            = 1,
    parameter int         WRAP            = 0,
    parameter int         FRAME_CYCLES    = 833333,
    parameter int         FRAMES_PER_STEP = 8,
    parameter logic [2:0] BG_COLOUR       = BLACK
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic       go,
    input  logic       pause,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic [7:0] obj_x,
    output logic [6:0] obj_y,
    output logic [2:0] current_state
);

    localparam int LIM = X_MAX + 1 - W;

    generate
        if (INIT_X > LIM || X_MAX >= SCREEN_W || INIT_Y + H > SCREEN_H) begin : g_bad_cfg
            $error("obstacle_sprite_mover: INIT_X exceeds X_MAX+1-W or sprite leaves the screen");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [4:0] cx_q, cx_d;
    logic [4:0] cy_q, cy_d;
    logic [7:0] pos_x_q, pos_x_d;
    logic       dir_q, dir_d;
    logic [7:0] obj_x_q, obj_x_d;
    logic       tmr_clr, tmr_en, step;
    logic [8:0] p9, s9, l9, sum9, diff9;

    frame_step_timer #(
        .FRAME_CYCLES    (FRAME_CYCLES),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_timer (
        .CLOCK (CLOCK),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .step  (step)
    );

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        pos_x_d = pos_x_q;
        dir_d   = dir_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        p9      = {1'b0, pos_x_q};
        s9      = 9'(STEP);
        l9      = 9'(LIM);
        sum9    = p9 + s9;
        diff9   = p9 - s9;

        case (state_q)
            IDLE:    if (go)  state_d = GO_WAIT;
            GO_WAIT: if (!go) state_d = PLOT;
            PLOT, ERASE: begin
                if (cx_q == 5'(W - 1)) begin
                    cx_d = '0;
                    if (cy_q == 5'(H - 1)) begin
                        cy_d    = '0;
                        state_d = (state_q == PLOT) ? RST_TMR : UPDATE;
                    end else begin
                        cy_d = cy_q + 5'd1;
                    end
                end else begin
                    cx_d = cx_q + 5'd1;
                end
            end
            RST_TMR: begin
                tmr_clr = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                tmr_en = !pause;
                if (step) state_d = ERASE;
            end
            UPDATE: begin
                state_d = PLOT;
                // Wrap keeps direction; bounce clamps to the edge and reverses.
                if (WRAP != 0) begin
                    if (dir_q) pos_x_d = (sum9 > l9) ? 8'd0 : sum9[7:0];
                    else       pos_x_d = (p9 < s9) ? l9[7:0] : diff9[7:0];
                end else if (dir_q) begin
                    if (sum9 >= l9) begin
                        pos_x_d = l9[7:0];
                        dir_d   = 1'b0;
                    end else begin
                        pos_x_d = sum9[7:0];
                    end
                end else begin
                    if (p9 <= s9) begin
                        pos_x_d = 8'd0;
                        dir_d   = 1'b1;
                    end else begin
                        pos_x_d = diff9[7:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        obj_x_d = pos_x_d;
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            pos_x_q <= 8'(INIT_X);
            dir_q   <= (INIT_DIR != 0);
            obj_x_q <= 8'(INIT_X);
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            pos_x_q <= pos_x_d;
            dir_q   <= dir_d;
            obj_x_q <= obj_x_d;
        end
    end

    always_comb begin
        writeEn       = (state_q == PLOT) || (state_q == ERASE);
        colour        = (state_q == ERASE) ? BG_COLOUR : colour_in;
        x             = pos_x_q + 8'(cx_q);
        y             = 7'(INIT_Y) + 7'(cy_q);
        obj_x         = obj_x_q;
        obj_y         = 7'(INIT_Y);
        current_state = state_q;
    end

endmodule
